acia_host: RTL

Hardware bus initiator for the `acia` peripheral, used where no 6502 core is present (bring-up and loopback builds). It drives the ACIA register port (`cs`/`we`/`rs`/data) directly. It runs the master-reset and configuration sequence, polls the status register, and moves bytes between two valid/ready byte streams and the ACIA data register. The block sits beside the ACIA in the top level, on the opposite side of the register interface from the ACIA.

---
 rtl/acia_pkg.sv | 23 ++
 rtl/acia_host.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/acia_pkg.sv
// Shared definitions for the acia peripheral and its hardware bus initiator.
package acia_pkg;

    // Status register bit positions
    localparam int unsigned RXF = 0;
    localparam int unsigned TXE = 1;
    localparam int unsigned ERR = 4;
    localparam int unsigned IRQ = 7;

    localparam logic [7:0] CTRL_MASTER_RESET = 8'h03;

    typedef enum logic [2:0] {
        StRstWr,
        StCfgWr,
        StIdle,
        StStatRd,
        StStatChk,
        StDataRd,
        StDataCap,
        StDataWr
    } state_e;

endpackage

// File: rtl/acia_host.sv
// Bus initiator for the acia register port: init sequence, status polling and
// byte transfer between valid/ready streams and the ACIA data register.
module acia_host
    import acia_pkg::*;
#(
    parameter logic [7:0]  CTRL_INIT = 8'h00,
    parameter int unsigned POLL_GAP  = 16,
    parameter int unsigned GW        = 8
) (
    input  logic       clk,
    input  logic       rst,
    output logic       bus_cs,
    output logic       bus_we,
    output logic       bus_rs,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    input  logic       acia_irq,
    input  logic [7:0] s_tx_data,
    input  logic       s_tx_valid,
    output logic       s_tx_ready,
    output logic [7:0] m_rx_data,
    output logic       m_rx_valid,
    input  logic       m_rx_ready,
    output logic [7:0] err_cnt
);

    state_e        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic [7:0]    err_q, err_d;
    logic          tx_accept;

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        tx_d       = tx_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        err_d      = err_q;
        tx_accept  = 1'b0;

        if (rx_valid_q && m_rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            StRstWr:  state_d = StCfgWr;
            StCfgWr:  state_d = StIdle;
            StIdle: begin
                if (gap_q == GW'(POLL_GAP) || acia_irq) begin
                    state_d = StStatRd;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StStatRd: state_d = StStatChk;
            StStatChk: begin
                if (bus_rdata[ERR] && err_q != 8'hFF) begin
                    err_d = err_q + 8'd1;
                end
                // A held RX byte blocks further reads; TX may still use this poll
                if (bus_rdata[RXF] && !rx_valid_q) begin
                    state_d = StDataRd;
                end else if (bus_rdata[TXE] && s_tx_valid) begin
                    tx_accept = 1'b1;
                    tx_d      = s_tx_data;
                    state_d   = StDataWr;
                end else begin
                    state_d = StIdle;
                end
            end
            StDataRd: state_d = StDataCap;
            StDataCap: begin
                rx_data_d  = bus_rdata;
                rx_valid_d = 1'b1;
                state_d    = StIdle;
            end
            StDataWr: state_d = StIdle;
            default:  state_d = StRstWr;
        endcase

        if (state_d == StIdle && state_q != StIdle) begin
            gap_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRstWr;
            gap_q      <= '0;
            tx_q       <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            err_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            tx_q       <= tx_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            err_q      <= err_d;
        end
    end

    // Bus strobes are a pure decode of state, masked while reset is held
    always_comb begin
        bus_cs    = 1'b0;
        bus_we    = 1'b0;
        bus_rs    = 1'b0;
        bus_wdata = 8'h00;
        if (!rst) begin
            case (state_q)
                StRstWr: begin
                    bus_cs    = 1'b1;
                    bus_we    = 1'b1;
                    bus_wdata = CTRL_MASTER_RESET;
                end
                StCfgWr: begin
                    bus_cs    = 1'b1;
                    bus_we    = 1'b1;
                    bus_wdata = CTRL_INIT;
                end
                StStatRd: bus_cs = 1'b1;
                StDataRd: begin
                    bus_cs = 1'b1;
                    bus_rs = 1'b1;
                end
                StDataWr: begin
                    bus_cs    = 1'b1;
                    bus_we    = 1'b1;
                    bus_rs    = 1'b1;
                    bus_wdata = tx_q;
                end
                default: ;
            endcase
        end
    end

    assign s_tx_ready = tx_accept & ~rst;
    assign m_rx_data  = rx_data_q;
    assign m_rx_valid = rx_valid_q;
    assign err_cnt    = err_q;

endmodule
